board_supervisor: RTL and testbench
===================================

// Module: board_supervisor
// PURPOSE
//  Board-level supervisor for the hx8k pool top: sequences PLL lock into a clean core reset.
//  Aggregates N per-core READY flags into the shared open-drain ready_n line.
//  Drives the status LED with state-dependent patterns; detects PLL lock loss while running.
//  Sits between the SB_PLL40_CORE/board pins and the pool top; generalises the fixed two-core wiring.
// PARAMETERS
//  NUM_CORES          2        number of pool cores aggregated (>=1)
//  LOCK_STABLE_CYCLES 1024     consecutive synced-lock cycles required before releasing reset (>=2)
//  RESET_HOLD_CYCLES  16       cycles core_reset_out stays high after lock is stable (>=1)
//  BLINK_DIV_LOG2     22       LED blink divider; fast blink = bit[BLINK_DIV_LOG2-2], slow = bit[BLINK_DIV_LOG2]
// PORTS
//  clk_in            in   1          PLL global clock (g_clk); the single clock domain
//  reset_in          in   1          synchronous, active-high reset
//  pll_locked_in     in   1          SB_PLL40_CORE LOCK, asynchronous; 2-flop synchronised internally
//  ext_reset_n_in    in   1          board reset pin, asynchronous, active-low; 2-flop synchronised
//  core_ready_in     in   NUM_CORES  per-core "nonce found", level, synchronous to clk_in
//  core_busy_in      in   NUM_CORES  per-core hashing-in-progress, level
//  core_reset_out    out  1          synchronous active-high reset to the pool cores
//  ready_n_od_out    out  1          open-drain ready: 1'b0 when ready latched, else 1'bz
//  status_led_n_out  out  1          active-low status LED
//  state_out         out  3          current FSM state encoding (debug/test)
// BEHAVIOUR
//  Reset (reset_in=1, or synced ext_reset_n=0 for >=1 cycle): state=WAIT_LOCK, core_reset_out=1,
//   ready latch=0 (ready_n_od_out=z), status_led_n_out=1, all counters=0. Reset mid-operation aborts
//   any state the next edge; counts never resume.
//  Synchronisers: lock_s = 2-flop(pll_locked_in); ext_rst_s = 2-flop(~ext_reset_n_in); 2-cycle latency.
//  FSM (one-hot or binary; encodings shared via package):
//   WAIT_LOCK(0): core_reset_out=1; lock_s=1 -> STABLE, lock_cnt=0.
//   STABLE(1):    lock_cnt++ per cycle while lock_s=1; lock_s=0 -> WAIT_LOCK (cnt cleared);
//                 lock_cnt==LOCK_STABLE_CYCLES-1 with lock_s=1 -> RELEASE, hold_cnt=0.
//   RELEASE(2):   core_reset_out=1; hold_cnt++; hold_cnt==RESET_HOLD_CYCLES-1 -> RUN;
//                 lock_s=0 -> WAIT_LOCK (takes priority over count expiry).
//   RUN(3):       core_reset_out=0 (registered; deasserts on the cycle after entering RUN).
//                 lock_s=0 -> FAULT.
//   FAULT(4):     core_reset_out=1 the next cycle; ready latch cleared.
//  Ready latch: set on any clock in RUN where |core_ready_in; cleared only by reset or FAULT/leaving RUN.
//   Set and lock-loss in the same cycle -> FAULT wins, latch stays 0. ready_n_od_out registered, 1-cycle latency.
//  LED: WAIT_LOCK off; STABLE/RELEASE fast blink; RUN on if |core_busy_in or latch, else off;
//   FAULT slow blink. Blink divider is a free-running BLINK_DIV_LOG2+1-bit counter, wraps, cleared by reset.
//  Counters sized $clog2 of their max; no overflow (terminal compare stops them).
// CONFIGURATION
//  `BOARD_SUPERVISOR_FAULT_LATCH_EN defined: FAULT is sticky; exit only via reset_in or ext reset.
//  Undefined: in FAULT, lock_s=1 -> STABLE (full re-qualification, lock_cnt=0); no other exit path.
// STRUCTURE
//  board_pkg (shared include/package): state encodings ST_WAIT_LOCK..ST_FAULT, STATE_W=3.
//  Sub-module sync_2ff (1-bit, no reset) instantiated twice for lock and ext reset.
//  Everything else (FSM, counters, latch, LED mux) flat in board_supervisor.
// TESTING (bench: LOCK_STABLE_CYCLES=8, RESET_HOLD_CYCLES=4, BLINK_DIV_LOG2=4, NUM_CORES=4)
//  1 reset_in pulse, lock=1 constant -> core_reset_out=1 for 2+8+4 cycles, drops exactly 1 cycle after RUN.
//  2 lock glitch low 1 cycle at lock_cnt=5 -> back to WAIT_LOCK, full 8-cycle count restarts.
//  3 RUN, core_ready_in=4'b0100 one cycle -> ready_n_od_out=0 next cycle, stays 0 after input drops.
//  4 RUN, lock drops same cycle as core_ready_in=4'b0001 -> FAULT, latch 0, ready_n=z, core_reset_out=1.
//  5 FAULT then lock=1: with _EN -> stays FAULT, LED toggles every 16 cycles; without -> STABLE, RUN after 8+4.
//  6 ext_reset_n_in low 1 cycle during RUN -> WAIT_LOCK within 3 cycles, LED=1, ready_n=z.

Source files
------------

// File: rtl/board_pkg.sv
// Shared definitions for the board supervisor: FSM state encodings and a
// counter-width helper. Imported by board_supervisor.
package board_pkg;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    ST_WAIT_LOCK = 3'd0,
    ST_STABLE    = 3'd1,
    ST_RELEASE   = 3'd2,
    ST_RUN       = 3'd3,
    ST_FAULT     = 3'd4
  } state_e;

  // Width of a counter that must hold values 0..max_count-1 (never zero bits).
  function automatic int cnt_width(input int max_count);
    return (max_count > 1) ? $clog2(max_count) : 1;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous level. No reset so the
// flops can be packed as a synchroniser pair.
module sync_2ff (
  input  logic clk_i,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  // Shift the asynchronous level through two flops.
  always_ff @(posedge clk_i) begin
    meta_q <= d_i;
    sync_q <= meta_q;
  end

  assign q_o = sync_q;

endmodule

// File: rtl/board_supervisor.sv
// Board supervisor: qualifies PLL lock into a clean core reset, aggregates
// per-core READY flags onto an open-drain line, drives a status LED and
// detects PLL lock loss while running.
// Build option: `BOARD_SUPERVISOR_FAULT_LATCH_EN makes FAULT sticky (exit
// only via reset_in or the board reset pin); otherwise a regained lock
// re-qualifies from STABLE.
module board_supervisor
  import board_pkg::*;
#(
  parameter int NUM_CORES          = 2,
  parameter int LOCK_STABLE_CYCLES = 1024,
  parameter int RESET_HOLD_CYCLES  = 16,
  parameter int BLINK_DIV_LOG2     = 22
) (
  input  logic                 clk_in,
  input  logic                 reset_in,
  input  logic                 pll_locked_in,
  input  logic                 ext_reset_n_in,
  input  logic [NUM_CORES-1:0] core_ready_in,
  input  logic [NUM_CORES-1:0] core_busy_in,
  output logic                 core_reset_out,
  output wire                  ready_n_od_out,
  output logic [STATE_W-1:0]   state_out,
  output logic                 status_led_n_out
);

  localparam int LOCK_W  = cnt_width(LOCK_STABLE_CYCLES);
  localparam int HOLD_W  = cnt_width(RESET_HOLD_CYCLES);
  localparam int BLINK_W = BLINK_DIV_LOG2 + 1;
  localparam logic [LOCK_W-1:0] LOCK_LAST = LOCK_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RESET_HOLD_CYCLES - 1);

  logic               lock_s;
  logic               ext_rst_s;
  state_e             state_q, state_d;
  logic [LOCK_W-1:0]  lock_cnt_q, lock_cnt_d;
  logic [HOLD_W-1:0]  hold_cnt_q, hold_cnt_d;
  logic [BLINK_W-1:0] blink_q, blink_d;
  logic               core_reset_q, core_reset_d;
  logic               ready_q, ready_d;
  logic               led_n_q, led_n_d;

  sync_2ff u_sync_lock (
    .clk_i (clk_in),
    .d_i   (pll_locked_in),
    .q_o   (lock_s)
  );

  sync_2ff u_sync_ext_rst (
    .clk_i (clk_in),
    .d_i   (~ext_reset_n_in),
    .q_o   (ext_rst_s)
  );

  // Next-state logic for the lock-qualification FSM and its two counters.
  always_comb begin
    state_d    = state_q;
    lock_cnt_d = lock_cnt_q;
    hold_cnt_d = hold_cnt_q;
    case (state_q)
      ST_WAIT_LOCK: begin
        lock_cnt_d = '0;
        hold_cnt_d = '0;
        if (lock_s) begin
          state_d = ST_STABLE;
        end else begin
          state_d = ST_WAIT_LOCK;
        end
      end
      ST_STABLE: begin
        if (!lock_s) begin
          state_d    = ST_WAIT_LOCK;
          lock_cnt_d = '0;
        end else if (lock_cnt_q == LOCK_LAST) begin
          state_d    = ST_RELEASE;
          lock_cnt_d = '0;
          hold_cnt_d = '0;
        end else begin
          lock_cnt_d = lock_cnt_q + LOCK_W'(1);
        end
      end
      ST_RELEASE: begin
        // Lock loss outranks hold expiry.
        if (!lock_s) begin
          state_d    = ST_WAIT_LOCK;
          hold_cnt_d = '0;
        end else if (hold_cnt_q == HOLD_LAST) begin
          state_d    = ST_RUN;
          hold_cnt_d = '0;
        end else begin
          hold_cnt_d = hold_cnt_q + HOLD_W'(1);
        end
      end
      ST_RUN: begin
        if (!lock_s) begin
          state_d = ST_FAULT;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_FAULT: begin
`ifdef BOARD_SUPERVISOR_FAULT_LATCH_EN
        state_d = ST_FAULT;
`else
        if (lock_s) begin
          state_d    = ST_STABLE;
          lock_cnt_d = '0;
        end else begin
          state_d = ST_FAULT;
        end
`endif
      end
      default: begin
        state_d    = ST_WAIT_LOCK;
        lock_cnt_d = '0;
        hold_cnt_d = '0;
      end
    endcase
  end

  // Registered output values: core reset, ready latch, LED pattern, blink divider.
  always_comb begin
    core_reset_d = (state_q != ST_RUN);
    blink_d      = blink_q + BLINK_W'(1);
    // Lock loss in the same cycle as a READY flag leaves the latch clear.
    if ((state_q == ST_RUN) && lock_s) begin
      ready_d = ready_q | (|core_ready_in);
    end else begin
      ready_d = 1'b0;
    end
    case (state_q)
      ST_WAIT_LOCK: led_n_d = 1'b1;
      ST_STABLE,
      ST_RELEASE:   led_n_d = blink_q[BLINK_DIV_LOG2-2];
      ST_RUN:       led_n_d = ~((|core_busy_in) | ready_q);
      ST_FAULT:     led_n_d = blink_q[BLINK_DIV_LOG2];
      default:      led_n_d = 1'b1;
    endcase
  end

  // State and output registers; either reset source aborts everything.
  always_ff @(posedge clk_in) begin
    if (reset_in || ext_rst_s) begin
      state_q      <= ST_WAIT_LOCK;
      lock_cnt_q   <= '0;
      hold_cnt_q   <= '0;
      blink_q      <= '0;
      core_reset_q <= 1'b1;
      ready_q      <= 1'b0;
      led_n_q      <= 1'b1;
    end else begin
      state_q      <= state_d;
      lock_cnt_q   <= lock_cnt_d;
      hold_cnt_q   <= hold_cnt_d;
      blink_q      <= blink_d;
      core_reset_q <= core_reset_d;
      ready_q      <= ready_d;
      led_n_q      <= led_n_d;
    end
  end

  assign core_reset_out   = core_reset_q;
  assign ready_n_od_out   = ready_q ? 1'b0 : 1'bz;
  assign state_out        = state_q;
  assign status_led_n_out = led_n_q;

endmodule

// File: tb/tb_board_supervisor.sv
// Self-checking bench for board_supervisor: directed vector table for the
// sequencing corner cases plus randomized traffic, all checked every cycle
// against a behavioural phase/age model.
module tb_board_supervisor;

  localparam int NC  = 4;
  localparam int LSC = 8;
  localparam int RHC = 4;
  localparam int BDL = 4;

  logic          clk = 1'b0;
  logic          reset_in;
  logic          pll;
  logic          ext_n;
  logic [NC-1:0] rdy_in;
  logic [NC-1:0] busy_in;
  logic          core_reset;
  wire           ready_n_w;
  logic [2:0]    state;
  logic          led_n;

  pullup (ready_n_w);

  board_supervisor #(
    .NUM_CORES          (NC),
    .LOCK_STABLE_CYCLES (LSC),
    .RESET_HOLD_CYCLES  (RHC),
    .BLINK_DIV_LOG2     (BDL)
  ) dut (
    .clk_in           (clk),
    .reset_in         (reset_in),
    .pll_locked_in    (pll),
    .ext_reset_n_in   (ext_n),
    .core_ready_in    (rdy_in),
    .core_busy_in     (busy_in),
    .core_reset_out   (core_reset),
    .ready_n_od_out   (ready_n_w),
    .state_out        (state),
    .status_led_n_out (led_n)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: phase 0..4 = wait-lock, stable, release, run, fault.
  // Synchronisers are a two-deep history of the raw pins.
  bit lk0 = 1'b1, lk1 = 1'b1, er0 = 1'b0, er1 = 1'b0;
  int m_phase = 0;
  int m_age   = 0;
  int m_blink = 0;
  bit m_cr    = 1'b1;
  bit m_latch = 1'b0;
  bit m_led   = 1'b1;

  task automatic model_step();
    bit ls, es, nled, nlatch, ncr;
    int nphase, nage;
    ls = lk1; es = er1;
    lk1 = lk0; lk0 = pll; er1 = er0; er0 = ~ext_n;
    if (reset_in || es) begin
      m_phase = 0; m_age = 0; m_blink = 0;
      m_cr = 1'b1; m_latch = 1'b0; m_led = 1'b1;
      return;
    end
    case (m_phase)
      1, 2:    nled = ((m_blink >> (BDL - 2)) & 1) != 0;
      3:       nled = !((busy_in != 0) || m_latch);
      4:       nled = ((m_blink >> BDL) & 1) != 0;
      default: nled = 1'b1;
    endcase
    ncr    = (m_phase != 3);
    nlatch = (m_phase == 3 && ls) ? (m_latch || (rdy_in != 0)) : 1'b0;
    nphase = m_phase;
    nage   = m_age + 1;
    if (m_phase == 0 && ls) begin
      nphase = 1; nage = 0;
    end else if ((m_phase == 1 || m_phase == 2) && !ls) begin
      nphase = 0; nage = 0;
    end else if (m_phase == 1 && m_age == LSC - 1) begin
      nphase = 2; nage = 0;
    end else if (m_phase == 2 && m_age == RHC - 1) begin
      nphase = 3; nage = 0;
    end else if (m_phase == 3 && !ls) begin
      nphase = 4; nage = 0;
`ifndef BOARD_SUPERVISOR_FAULT_LATCH_EN
    end else if (m_phase == 4 && ls) begin
      nphase = 1; nage = 0;
`endif
    end
    m_phase = nphase; m_age = nage;
    m_led = nled; m_cr = ncr; m_latch = nlatch;
    m_blink = (m_blink + 1) % (1 << (BDL + 1));
  endtask

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, exp, $time);
    end
  endtask

  // One clock: model advances on the edge, outputs compared on the falling edge.
  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    chk("model_state", {5'd0, state}, 8'(m_phase));
    chk("model_core_reset", {7'd0, core_reset}, {7'd0, m_cr});
    chk("model_ready_n", {7'd0, ready_n_w}, {7'd0, ~m_latch});
    chk("model_led_n", {7'd0, led_n}, {7'd0, m_led});
  endtask

  typedef struct {
    logic          rst, lock, ext_n;
    logic [NC-1:0] ready, busy;
    int            ncyc;
    logic [2:0]    st;
    logic          cr, rdy_n;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r, input logic l, input logic e, input logic [NC-1:0] rd,
                     input logic [NC-1:0] bz, input int n, input logic [2:0] s,
                     input logic c, input logic q);
    vec_t v;
    v.rst = r; v.lock = l; v.ext_n = e; v.ready = rd; v.busy = bz;
    v.ncyc = n; v.st = s; v.cr = c; v.rdy_n = q;
    vecs.push_back(v);
  endtask

  initial begin
    reset_in = 1'b1; pll = 1'b1; ext_n = 1'b1; rdy_in = '0; busy_in = '0;

    // Power-up sequencing: 1 wait-lock, 8 stable, 4 release, reset drops one after RUN.
    add(1'b1, 1'b1, 1'b1, 4'h0, 4'h0, 4,  3'd0, 1'b1, 1'b1);
    add(1'b0, 1'b1, 1'b1, 4'h0, 4'h0, 1,  3'd1, 1'b1, 1'b1);
    add(1'b0, 1'b1, 1'b1, 4'h0, 4'h0, 8,  3'd2, 1'b1, 1'b1);
    add(1'b0, 1'b1, 1'b1, 4'h0, 4'h0, 4,  3'd3, 1'b1, 1'b1);
    add(1'b0, 1'b1, 1'b1, 4'h0, 4'h0, 1,  3'd3, 1'b0, 1'b1);
    // One-cycle ready flag latches and holds.
    add(1'b0, 1'b1, 1'b1, 4'h4, 4'h0, 1,  3'd3, 1'b0, 1'b0);
    add(1'b0, 1'b1, 1'b1, 4'h0, 4'h0, 3,  3'd3, 1'b0, 1'b0);
    // Lock loss coinciding with ready: FAULT wins, latch stays clear.
    add(1'b1, 1'b1, 1'b1, 4'h0, 4'h0, 3,  3'd0, 1'b1, 1'b1);
    add(1'b0, 1'b1, 1'b1, 4'h0, 4'h0, 13, 3'd3, 1'b1, 1'b1);
    add(1'b0, 1'b0, 1'b1, 4'h0, 4'h0, 2,  3'd3, 1'b0, 1'b1);
    add(1'b0, 1'b0, 1'b1, 4'h1, 4'h0, 1,  3'd4, 1'b0, 1'b1);
    add(1'b0, 1'b0, 1'b1, 4'h0, 4'h0, 1,  3'd4, 1'b1, 1'b1);
    // Lock returns while in FAULT.
    add(1'b0, 1'b1, 1'b1, 4'h0, 4'h0, 2,  3'd4, 1'b1, 1'b1);
`ifdef BOARD_SUPERVISOR_FAULT_LATCH_EN
    add(1'b0, 1'b1, 1'b1, 4'h0, 4'h0, 1,  3'd4, 1'b1, 1'b1);
    add(1'b0, 1'b1, 1'b1, 4'h0, 4'h0, 8,  3'd4, 1'b1, 1'b1);
    add(1'b0, 1'b1, 1'b1, 4'h0, 4'h0, 4,  3'd4, 1'b1, 1'b1);
    add(1'b0, 1'b1, 1'b1, 4'h0, 4'h0, 1,  3'd4, 1'b1, 1'b1);
`else
    add(1'b0, 1'b1, 1'b1, 4'h0, 4'h0, 1,  3'd1, 1'b1, 1'b1);
    add(1'b0, 1'b1, 1'b1, 4'h0, 4'h0, 8,  3'd2, 1'b1, 1'b1);
    add(1'b0, 1'b1, 1'b1, 4'h0, 4'h0, 4,  3'd3, 1'b1, 1'b1);
    add(1'b0, 1'b1, 1'b1, 4'h0, 4'h0, 1,  3'd3, 1'b0, 1'b1);
`endif
    // Lock glitch at count 5 restarts the full qualification.
    add(1'b1, 1'b1, 1'b1, 4'h0, 4'h0, 3,  3'd0, 1'b1, 1'b1);
    add(1'b0, 1'b1, 1'b1, 4'h0, 4'h0, 4,  3'd1, 1'b1, 1'b1);
    add(1'b0, 1'b0, 1'b1, 4'h0, 4'h0, 1,  3'd1, 1'b1, 1'b1);
    add(1'b0, 1'b1, 1'b1, 4'h0, 4'h0, 1,  3'd1, 1'b1, 1'b1);
    add(1'b0, 1'b1, 1'b1, 4'h0, 4'h0, 1,  3'd0, 1'b1, 1'b1);
    add(1'b0, 1'b1, 1'b1, 4'h0, 4'h0, 1,  3'd1, 1'b1, 1'b1);
    add(1'b0, 1'b1, 1'b1, 4'h0, 4'h0, 7,  3'd1, 1'b1, 1'b1);
    add(1'b0, 1'b1, 1'b1, 4'h0, 4'h0, 1,  3'd2, 1'b1, 1'b1);
    // Board reset pulse during RUN aborts through the synchroniser.
    add(1'b0, 1'b1, 1'b1, 4'h0, 4'h0, 4,  3'd3, 1'b1, 1'b1);
    add(1'b0, 1'b1, 1'b1, 4'h0, 4'h0, 1,  3'd3, 1'b0, 1'b1);
    add(1'b0, 1'b1, 1'b1, 4'h2, 4'h1, 1,  3'd3, 1'b0, 1'b0);
    add(1'b0, 1'b1, 1'b0, 4'h0, 4'h1, 1,  3'd3, 1'b0, 1'b0);
    add(1'b0, 1'b1, 1'b1, 4'h0, 4'h1, 1,  3'd3, 1'b0, 1'b0);
    add(1'b0, 1'b1, 1'b1, 4'h0, 4'h1, 1,  3'd0, 1'b1, 1'b1);

    @(negedge clk);
    for (int i = 0; i < vecs.size(); i++) begin
      reset_in = vecs[i].rst; pll = vecs[i].lock; ext_n = vecs[i].ext_n;
      rdy_in = vecs[i].ready; busy_in = vecs[i].busy;
      for (int c = 0; c < vecs[i].ncyc; c++) tick();
      chk($sformatf("vec%0d_state", i), {5'd0, state}, {5'd0, vecs[i].st});
      chk($sformatf("vec%0d_core_reset", i), {7'd0, core_reset}, {7'd0, vecs[i].cr});
      chk($sformatf("vec%0d_ready_n", i), {7'd0, ready_n_w}, {7'd0, vecs[i].rdy_n});
    end
    chk("ext_reset_led_off", {7'd0, led_n}, 8'd1);

    // Randomized traffic: mostly-stable lock with glitches, sparse resets.
    for (int c = 0; c < 1500; c++) begin
      reset_in = ($urandom_range(0, 249) == 0);
      ext_n    = ($urandom_range(0, 299) != 0);
      pll      = ($urandom_range(0, 39) != 0);
      rdy_in   = ($urandom_range(0, 5) == 0) ? NC'($urandom) : '0;
      busy_in  = NC'($urandom);
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
